// File: rtl/img_rom_streamer.sv
// Streams a raster frame from a fixed-latency block ROM as a tagged valid/ready pixel stream.
// Define IMG_STREAM_LOOP_EN to add the loop port for back-to-back frame repetition.
module img_rom_streamer #(
    parameter int PIX_W     = 24,
    parameter int IMG_W     = 512,
    parameter int IMG_H     = 512,
    parameter int ADDR_W    = 18,
    parameter int BASE_ADDR = 0,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef IMG_STREAM_LOOP_EN
    input  logic              loop,
`endif
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic              busy,
    output logic              frame_done
);
    localparam int DEPTH = RD_LAT + 2;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = 4;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;

    logic [ADDR_W-1:0] idx;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic              last_idx, tag_sof, tag_eol, tag_eof, loop_go, hs;
    logic [RD_LAT-1:0] pv;
    logic [2:0]        ptag [RD_LAT];
    logic [CW-1:0]     in_flight, fifo_count;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PIX_W+2:0]  fifo_mem [DEPTH];
    logic [PIX_W+2:0]  head;
    logic              push;

`ifdef IMG_STREAM_LOOP_EN
    assign loop_go = loop;
`else
    assign loop_go = 1'b0;
`endif

    assign last_idx = (idx == ADDR_W'(NPIX - 1));
    assign tag_sof  = (x == '0) && (y == '0);
    assign tag_eol  = (x == XW'(IMG_W - 1));
    assign tag_eof  = tag_eol && (y == YW'(IMG_H - 1));
    assign mem_addr = ADDR_W'(BASE_ADDR) + idx;
    assign hs       = m_valid && m_ready;
    assign push     = pv[RD_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // DRAIN exits only on the final outstanding beat, so a short looped frame
    // whose previous eof is still queued cannot end the drain early.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (mem_en && last_idx && !loop_go) state_nx = DRAIN;
            DRAIN:   if (hs && m_eof && in_flight == '0 && fifo_count == CW'(1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        mem_en = (state == RUN) && ((in_flight + fifo_count) < CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            x   <= '0;
            y   <= '0;
        end else if (state == IDLE || (mem_en && last_idx)) begin
            idx <= '0;
            x   <= '0;
            y   <= '0;
        end else if (mem_en) begin
            idx <= idx + ADDR_W'(1);
            if (tag_eol) begin
                x <= '0;
                y <= y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) ptag[i] <= '0;
        end else begin
            pv[0]   <= mem_en;
            ptag[0] <= {tag_sof, tag_eol, tag_eof};
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pv[i]   <= pv[i-1];
                ptag[i] <= ptag[i-1];
            end
        end
    end

    always_comb begin
        in_flight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) in_flight = in_flight + CW'(pv[i]);
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {mem_rdata, ptag[RD_LAT-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            frame_done <= 1'b0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (hs)   rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(hs);
            frame_done <= hs && m_eof;
        end
    end

    assign head    = fifo_mem[rd_ptr];
    assign m_valid = (fifo_count != '0);
    assign m_data  = m_valid ? head[PIX_W+2:3] : '0;
    assign m_sof   = m_valid && head[2];
    assign m_eol   = m_valid && head[1];
    assign m_eof   = m_valid && head[0];
endmodule

// File: tb/tb_img_rom_streamer.sv
// Scoreboard bench for img_rom_streamer: 4x3 frame at base 16, ROM returns its address.
// Two instances (RD_LAT=1 and RD_LAT=3); sel picks which one is driven and observed.
module tb_img_rom_streamer;
    localparam int PIX_W = 24;
    localparam int AW    = 8;

    typedef struct packed {
        logic [PIX_W-1:0] d;
        logic sof;
        logic eol;
        logic eof;
    } beat_t;

    logic clk, rst_n, start, m_ready, sel, loop;

    logic mem_en1, mem_en3, v1, v3, sof1, sof3, eol1, eol3, eof1, eof3, busy1, busy3, fd1, fd3;
    logic [AW-1:0] addr1, addr3;
    logic [PIX_W-1:0] rd1, rd3, d1, d3, rd3a, rd3b;

    img_rom_streamer #(.PIX_W(PIX_W), .IMG_W(4), .IMG_H(3), .ADDR_W(AW), .BASE_ADDR(16), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel),
`ifdef IMG_STREAM_LOOP_EN
        .loop(loop),
`endif
        .mem_en(mem_en1), .mem_addr(addr1), .mem_rdata(rd1), .m_data(d1), .m_valid(v1),
        .m_ready(sel ? 1'b1 : m_ready), .m_sof(sof1), .m_eol(eol1), .m_eof(eof1),
        .busy(busy1), .frame_done(fd1));

    img_rom_streamer #(.PIX_W(PIX_W), .IMG_W(4), .IMG_H(3), .ADDR_W(AW), .BASE_ADDR(16), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start & sel),
`ifdef IMG_STREAM_LOOP_EN
        .loop(loop),
`endif
        .mem_en(mem_en3), .mem_addr(addr3), .mem_rdata(rd3), .m_data(d3), .m_valid(v3),
        .m_ready(sel ? m_ready : 1'b1), .m_sof(sof3), .m_eol(eol3), .m_eof(eof3),
        .busy(busy3), .frame_done(fd3));

    always @(posedge clk) begin
        rd1  <= PIX_W'(addr1);
        rd3a <= PIX_W'(addr3);
        rd3b <= rd3a;
        rd3  <= rd3b;
    end

    wire o_valid = sel ? v3 : v1;
    wire o_sof = sel ? sof3 : sof1;
    wire o_eol = sel ? eol3 : eol1;
    wire o_eof = sel ? eof3 : eof1;
    wire o_busy = sel ? busy3 : busy1;
    wire o_fd = sel ? fd3 : fd1;
    wire o_mem_en = sel ? mem_en3 : mem_en1;
    wire [AW-1:0] o_addr = sel ? addr3 : addr1;
    wire [PIX_W-1:0] o_data = sel ? d3 : d1;

    int checks = 0, failures = 0;
    int cyc = 0, start_cyc = 0, last_hs = 0, beat_n = 0, fd_count = 0, lat_exp = 2;
    bit stall_prev = 0, eof_hs_prev = 0, first_pending = 0, contig = 0;
    beat_t prev_beat;
    beat_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame();
        beat_t b;
        for (int i = 0; i < 12; i++) begin
            b.d   = PIX_W'(16 + i);
            b.sof = (i == 0);
            b.eol = (i % 4 == 3);
            b.eof = (i == 11);
            sb.push_back(b);
        end
    endtask

    // One clock: observe at the falling edge, then return #1 after the rising edge.
    task automatic tick();
        beat_t cur, e;
        logic hs;
        @(negedge clk);
        cur = {o_data, o_sof, o_eol, o_eof};
        if (sel) check("credit_bound_lat3", 64'((dut3.in_flight + dut3.fifo_count) <= 5), 1);
        else     check("credit_bound_lat1", 64'((dut1.in_flight + dut1.fifo_count) <= 3), 1);
        if (stall_prev) begin
            check("stall_valid_hold", o_valid, 1);
            check("stall_beat_hold", cur, prev_beat);
        end
        check("frame_done_pulse", o_fd, eof_hs_prev);
        if (o_fd) begin
            fd_count++;
            if (!loop) check("busy_after_done", o_busy, 0);
        end
        if (first_pending && o_valid) begin
            check("first_valid_latency", 64'(cyc - start_cyc), 64'(lat_exp));
            first_pending = 0;
        end
        hs = o_valid & m_ready;
        if (hs) begin
            check("beat_expected", 64'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("beat", cur, e);
            end
            if (contig && beat_n > 0) check("contiguous_beats", 64'(cyc - last_hs), 1);
            last_hs = cyc;
            beat_n++;
        end
        stall_prev  = o_valid & ~m_ready;
        prev_beat   = cur;
        eof_hs_prev = hs & o_eof;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
        first_pending = 1;
        beat_n = 0;
        check("busy_after_start", o_busy, 1);
        check("mem_en_after_start", o_mem_en, 1);
        check("first_addr", o_addr, 16);
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int n = 0;
        while (!(o_busy == 1'b0 && sb.size() == 0) && n < budget) begin
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        m_ready = 1'b1;
        check("frame_within_budget", 64'(n < budget), 1);
        tick();
        tick();
    endtask

    task automatic check_reset();
        check("rst_mem_en", o_mem_en, 0);
        check("rst_mem_addr", o_addr, 16);
        check("rst_m_valid", o_valid, 0);
        check("rst_m_data", o_data, 0);
        check("rst_tags", {o_sof, o_eol, o_eof}, 0);
        check("rst_busy", o_busy, 0);
        check("rst_frame_done", o_fd, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, fd0;
        bit hit;
        clk = 0; rst_n = 0; start = 0; m_ready = 1; sel = 0; loop = 0;
        #1;
        check_reset();
        tick();
        tick();
        rst_n = 1;
        tick();

        // One frame, RD_LAT=1, full throughput
        contig = 1; lat_exp = 2; fd0 = fd_count;
        push_frame();
        do_start();
        wait_done(60, 0);
        check("one_shot_frame_done_count", 64'(fd_count - fd0), 1);

        // Random backpressure
        contig = 0;
        push_frame();
        do_start();
        wait_done(300, 1);

        // RD_LAT=3, full throughput
        sel = 1; contig = 1; lat_exp = 4;
        tick();
        push_frame();
        do_start();
        wait_done(60, 0);
        sel = 0; lat_exp = 2;
        tick();

        // Start pulsed mid-frame and on the eof handshake cycle
        push_frame();
        do_start();
        repeat (4) tick();
        start = 1;
        tick();
        start = 0;
        n = 0; hit = 0;
        while (o_busy && n < 60) begin
            start = o_valid & o_eof & m_ready;
            if (start) hit = 1;
            tick();
            n++;
        end
        start = 0;
        check("eof_start_budget", 64'(n < 60), 1);
        check("eof_start_applied", 64'(hit), 1);
        repeat (6) tick();
        check("no_extra_frame_busy", o_busy, 0);
        check("no_extra_frame_sb", 64'(sb.size()), 0);
        push_frame();
        do_start();
        wait_done(60, 0);

        // Reset mid-frame after beat 5
        push_frame();
        do_start();
        n = 0;
        while (beat_n < 6 && n < 60) begin
            tick();
            n++;
        end
        check("reach_beat6_budget", 64'(n < 60), 1);
        rst_n = 0;
        #1;
        check_reset();
        sb.delete();
        stall_prev = 0; eof_hs_prev = 0; first_pending = 0;
        tick();
        tick();
        check_reset();
        rst_n = 1;
        push_frame();
        do_start();
        wait_done(60, 0);

`ifdef IMG_STREAM_LOOP_EN
        // Looping: two full frames back-to-back, loop dropped during the third
        contig = 1; loop = 1; fd0 = fd_count;
        push_frame();
        push_frame();
        push_frame();
        do_start();
        n = 0;
        while (beat_n < 26 && n < 100) begin
            tick();
            n++;
        end
        check("loop_reach_budget", 64'(n < 100), 1);
        loop = 0;
        wait_done(100, 0);
        check("loop_frame_done_count", 64'(fd_count - fd0), 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/img_rom_streamer.md
# img_rom_streamer

Parametrised image streamer that reads a raster frame from a fixed-latency block ROM and presents it as a valid/ready pixel stream. Pixels carry start-of-frame, end-of-line and end-of-frame tags. It sits between the on-chip image ROM and downstream image-processing stages. Compared with a free-running address counter, it adds:
- explicit start control;
- output data aligned to the ROM read latency;
- downstream backpressure;
- optional frame looping.

## Interface
Parameters:
- PIX_W, 24: pixel width in bits.
- IMG_W, 512: pixels per line (≥2).
- IMG_H, 512: lines per frame (≥1).
- ADDR_W, 18: ROM address width; must satisfy 2^ADDR_W ≥ BASE_ADDR + IMG_W*IMG_H.
- BASE_ADDR, 0: ROM address of pixel (0,0).
- RD_LAT, 1: ROM read latency in cycles, 1..4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a frame; ignored while busy=1.
- loop  in  1  present only with IMG_STREAM_LOOP_EN; repeat frames back-to-back.
- mem_en  out  1  ROM read enable.
- mem_addr  out  ADDR_W  ROM read address.
- mem_rdata  in  PIX_W  ROM data, valid RD_LAT cycles after the mem_en cycle.
- m_data  out  PIX_W  pixel.
- m_valid  out  1  pixel valid.
- m_ready  in  1  downstream accept.
- m_sof  out  1  beat is pixel (0,0).
- m_eol  out  1  beat is the last pixel of a line.
- m_eof  out  1  beat is the last pixel of the frame.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the eof beat is accepted.

## Operation
- State machine: IDLE, RUN, DRAIN.
  - IDLE: start=1 → RUN. Pixel index, x and y clear to 0.
  - RUN: issues reads. After issuing the read for index IMG_W*IMG_H-1, moves to DRAIN; with looping active, it wraps instead (see Configuration).
  - DRAIN: issues no reads. When the eof beat is handshaken (m_valid & m_ready & m_eof) → IDLE.
- busy = 1 in RUN and DRAIN.
- Read issue:
  - mem_en = (state==RUN) & (in_flight + fifo_count < RD_LAT+2).
  - mem_addr = BASE_ADDR + index (linear, row-major).
  - index, x and y advance only on mem_en. x wraps at IMG_W-1, which increments y.
- Tag pipeline:
  - An RD_LAT-deep shift register carries a valid bit plus the sof/eol/eof tags alongside each read.
  - sof = (x==0 & y==0); eol = (x==IMG_W-1); eof = eol & (y==IMG_H-1).
- Output FIFO:
  - Depth RD_LAT+2; entries are {mem_rdata, tags}.
  - Written when the tag pipeline output is valid; popped on m_valid & m_ready.
  - The credit rule guarantees it never overflows.
  - m_valid = fifo non-empty; m_data and tags come from the FIFO head.
- While m_valid=1 and m_ready=0: m_data and tags hold stable, and m_valid stays 1.
- start while busy: ignored, no effect.

## Timing
- Reset values: mem_en=0, mem_addr=BASE_ADDR, m_valid=0, m_data=0, m_sof=m_eol=m_eof=0, busy=0, frame_done=0. FIFO and tag pipeline are empty; state is IDLE.
- start is sampled at edge k:
  - busy=1 after edge k.
  - First mem_en is high in the cycle after edge k.
  - First m_valid is high after edge k+RD_LAT+1.
- Throughput: 1 pixel/cycle for any RD_LAT while m_ready=1.
- frame_done is high for exactly one cycle, after the edge on which the eof beat is accepted. busy falls on that same edge in one-shot mode.
- rst_n asserted mid-frame: all outputs take their reset values immediately. In-flight reads are discarded. The next start begins again at BASE_ADDR.
- start on the same edge as the eof handshake: ignored (busy still 1).

## Configuration
- IMG_STREAM_LOOP_EN defined:
  - The loop port exists.
  - loop is sampled on the cycle that issues the last index. If loop=1, index, x and y wrap to 0 and RUN continues with no bubble. If loop=0, the block moves to DRAIN.
  - frame_done pulses once per frame.
- IMG_STREAM_LOOP_EN undefined: no loop port; every start produces exactly one frame.

## Test plan
Bench parameters: IMG_W=4, IMG_H=3, BASE_ADDR=16, ROM model returns mem_rdata = address.
- One frame, RD_LAT=1, m_ready=1, start pulse:
  - 12 consecutive beats, data 16..27.
  - sof on beat 0; eol on beats 3, 7, 11; eof on beat 11.
  - First m_valid 2 cycles after the start edge.
  - frame_done 1 cycle after beat 11; busy=0 afterwards.
- Random m_ready (50%), RD_LAT=1:
  - Data 16..27 in order, no drop or duplicate.
  - m_data and tags stable during stalls.
  - in_flight + fifo_count ≤ 3 at all times.
- RD_LAT=3, m_ready=1: 12 beats on 12 consecutive cycles; first m_valid 4 cycles after the start edge.
- start pulsed mid-frame and on the eof handshake cycle: no extra frame and no address disturbance. A later start in IDLE produces a new frame 16..27.
- rst_n low after beat 5 (2 cycles): all outputs at reset values. The next start yields data from 16 with sof on the first beat.
- With IMG_STREAM_LOOP_EN, loop=1: 24 consecutive beats with sof on beats 0 and 12 and frame_done twice. loop dropped during frame 3: stream stops after that frame's eof.
